// File: rtl/pe_input_fifo.sv
// PE input FIFO: show-ahead queue with count, almost-full and sticky overflow.
// Pointers carry one wrap bit above the index so full and empty stay distinct.
module pe_input_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full,
  output logic                       overflow,
  input  logic                       clear
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF = PW'(AF_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
              && (wr_ptr[AW] != rd_ptr[AW]);

  assign in_ready    = !full;
  assign out_valid   = !empty;
  assign out_data    = mem[rd_ptr[AW-1:0]];
  assign count       = wr_ptr - rd_ptr;
  assign almost_full = (count >= AF);

  assign push = in_valid && !full && !clear;
  assign pop  = out_ready && !empty && !clear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (in_valid && full)
        overflow <= 1'b1;
    end
  end

  // Storage is deliberately left unreset; only pushes touch it.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_pe_input_fifo.sv
// Bench for pe_input_fifo: queue-based reference model compared every cycle,
// directed scenarios pinned with literal expectations, then random traffic.
module tb_pe_input_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AFL   = DEPTH - 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [3:0]    count;
  logic          almost_full;
  logic          overflow;
  logic          clear;

  pe_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .count(count),
    .almost_full(almost_full),
    .overflow(overflow),
    .clear(clear)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] q[$];
  logic          m_ovf;
  int            checks = 0;
  int            passed = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endtask

  // Reference behaviour at a rising edge, from the sampled inputs.
  task automatic model_edge();
    bit was_full;
    bit was_empty;
    if (!reset) return;
    if (clear) begin
      q.delete();
      m_ovf = 1'b0;
      return;
    end
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (in_valid && was_full) m_ovf = 1'b1;
    if (out_ready && !was_empty) void'(q.pop_front());
    if (in_valid && !was_full) q.push_back(in_data);
  endtask

  task automatic cmp();
    chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("count", 32'(count), 32'(q.size()));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= AFL));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cmp();
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clear     = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    in_data = '0;
    idle();
    m_ovf = 1'b0;
    #3;
    cmp();
    @(negedge clk);
    reset = 1'b1;
    cyc();

    // Fill to full, checking almost_full threshold
    for (int i = 1; i <= DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      cyc();
      if (i == 5) chk("af_at5", 32'(almost_full), 32'd0);
      if (i == 6) chk("af_at6", 32'(almost_full), 32'd1);
    end
    idle();
    chk("full_count", 32'(count), 32'd8);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    for (int i = 1; i <= DEPTH; i++) begin
      chk("drain_data", 32'(out_data), 32'(i));
      out_ready = 1'b1;
      cyc();
    end
    idle();
    chk("drained_count", 32'(count), 32'd0);
    chk("drained_valid", 32'(out_valid), 32'd0);

    // Write while full with concurrent pop
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(16'h0040 + i);
      cyc();
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = 16'hDEAD;
    cyc();
    idle();
    chk("ovf_count", 32'(count), 32'd7);
    chk("ovf_set", 32'(overflow), 32'd1);
    cyc();
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Down to 5, then clear with a concurrent write
    out_ready = 1'b1;
    cyc();
    cyc();
    idle();
    chk("pre_clear_count", 32'(count), 32'd5);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h7777;
    cyc();
    idle();
    chk("clear_count", 32'(count), 32'd0);
    chk("clear_ovf", 32'(overflow), 32'd0);
    chk("clear_valid", 32'(out_valid), 32'd0);
    cyc();
    chk("clear_not_stored", 32'(out_valid), 32'd0);

    // Fall-through of a single word
    in_valid = 1'b1;
    in_data  = 16'hABCD;
    cyc();
    idle();
    chk("ft_valid", 32'(out_valid), 32'd1);
    chk("ft_data", 32'(out_data), 32'hABCD);
    out_ready = 1'b1;
    cyc();
    idle();
    chk("ft_empty", 32'(out_valid), 32'd0);

    // Half-full streaming across pointer wrap
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(16'h0100 + i);
      cyc();
    end
    for (int i = 0; i < 20; i++) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_data   = DW'(16'h0200 + i);
      cyc();
      chk("stream_count", 32'(count), 32'd4);
    end
    chk("stream_head", 32'(out_data), 32'h0210);
    idle();

    // Asynchronous reset mid-cycle with 3 queued
    clear = 1'b1;
    cyc();
    idle();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(16'h0030 + i);
      cyc();
    end
    idle();
    #2;
    reset = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    cmp();
    reset = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0055;
    cyc();
    idle();
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_data", 32'(out_data), 32'h0055);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 45);
      in_data   = DW'($urandom);
      clear     = ($urandom_range(0, 127) == 0);
      cyc();
    end
    idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
